// File: rtl/eater_pkg.sv
// Shared definitions for the eater_cpu accumulator machine:
// opcode values, control state encoding and default widths.
package eater_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_ADDR_W = 4;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_LDA = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_SUB = 4'h3;
   localparam logic [3:0] OP_STA = 4'h4;
   localparam logic [3:0] OP_LDI = 4'h5;
   localparam logic [3:0] OP_JMP = 4'h6;
   localparam logic [3:0] OP_JC  = 4'h7;
   localparam logic [3:0] OP_JZ  = 4'h8;
   localparam logic [3:0] OP_OUT = 4'hE;
   localparam logic [3:0] OP_HLT = 4'hF;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_MEM_RD,
      S_ALU,
      S_MEM_WR,
      S_HALT
   } state_t;

endpackage

// File: rtl/eater_cpu_alu.sv
// Combinational add/subtract unit with carry-out and zero detect.
// Subtraction is a + ~b + 1, so carry=1 means no borrow.
module alu_n #(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         sub,
   output logic [W-1:0] y,
   output logic         carry,
   output logic         zero
);

   logic [W:0] sum;

   always_comb begin
      sum   = {1'b0, a}
            + {1'b0, (sub ? ~b : b)}
            + {{W{1'b0}}, sub};
      y     = sum[W-1:0];
      carry = sum[W];
      zero  = (sum[W-1:0] == '0);
   end

endmodule

// File: rtl/eater_cpu.sv
// Multi-cycle accumulator CPU with a req/ack memory port,
// free-run or single-step execution and an output register.
module eater_cpu
   import eater_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              run_en,
   input  logic              step_pulse,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              halted,
   output logic              cf,
   output logic              zf
);

   if (DATA_W < 4 + ADDR_W) begin : g_width_check
      $error("eater_cpu: DATA_W must be >= 4 + ADDR_W");
   end

   state_t state;
   state_t nxt;

   logic [DATA_W-1:0] a;
   logic [DATA_W-1:0] b;
   logic [DATA_W-1:0] ir;
   logic [ADDR_W-1:0] pc;

   logic [3:0]        opcode;
   logic [ADDR_W-1:0] operand;
   logic [DATA_W-1:0] alu_y;
   logic              alu_c;
   logic              alu_z;
   logic              unused_ir;

   assign opcode    = ir[DATA_W-1 -: 4];
   assign operand   = ir[ADDR_W-1:0];
   assign unused_ir = ^ir;

   alu_n #(.W(DATA_W)) u_alu (
      .a     (a),
      .b     (b),
      .sub   (opcode == OP_SUB),
      .y     (alu_y),
      .carry (alu_c),
      .zero  (alu_z)
   );

   // Bus signals depend on state and registers only.
   assign mem_req   = (state == S_FETCH)
                   || (state == S_MEM_RD)
                   || (state == S_MEM_WR);
   assign mem_we    = (state == S_MEM_WR);
   assign mem_addr  = (state == S_FETCH) ? pc : operand;
   assign mem_wdata = a;
   assign halted    = (state == S_HALT);

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) state <= S_IDLE;
      else      state <= nxt;
   end

   always_comb begin
      nxt = state;
      unique case (state)
         S_IDLE:
            if (run_en || step_pulse) nxt = S_FETCH;
         S_FETCH:
            if (mem_ack) nxt = S_DECODE;
         S_DECODE:
            unique case (1'b1)
               (opcode == OP_LDA),
               (opcode == OP_ADD),
               (opcode == OP_SUB): nxt = S_MEM_RD;
               (opcode == OP_STA): nxt = S_MEM_WR;
               (opcode == OP_HLT): nxt = S_HALT;
               default:            nxt = S_IDLE;
            endcase
         S_MEM_RD:
            if (mem_ack)
               nxt = (opcode == OP_LDA) ? S_IDLE : S_ALU;
         S_ALU:
            nxt = S_IDLE;
         S_MEM_WR:
            if (mem_ack) nxt = S_IDLE;
         S_HALT:
            nxt = S_HALT;
         default:
            nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         a         <= '0;
         b         <= '0;
         ir        <= '0;
         pc        <= '0;
         cf        <= 1'b0;
         zf        <= 1'b0;
         out_data  <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         unique case (state)
            S_FETCH:
               if (mem_ack) begin
                  ir <= mem_rdata;
                  pc <= pc + {{(ADDR_W-1){1'b0}}, 1'b1};
               end
            S_DECODE:
               unique case (1'b1)
                  (opcode == OP_LDI):
                     a <= {{(DATA_W-ADDR_W){1'b0}}, operand};
                  (opcode == OP_JMP):
                     pc <= operand;
                  (opcode == OP_JC):
                     if (cf) pc <= operand;
                  (opcode == OP_JZ):
                     if (zf) pc <= operand;
                  (opcode == OP_OUT): begin
                     out_data  <= a;
                     out_valid <= 1'b1;
                  end
                  default: ;
               endcase
            S_MEM_RD:
               if (mem_ack) begin
                  if (opcode == OP_LDA) a <= mem_rdata;
                  else                  b <= mem_rdata;
               end
            S_ALU: begin
               a  <= alu_y;
               cf <= alu_c;
               zf <= alu_z;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_eater_cpu.sv
// Directed and random-program checks of eater_cpu against an
// instruction-level reference model.
module tb_eater_cpu;

   logic       clk = 1'b0;
   logic       clr = 1'b0;
   logic       run_en = 1'b0;
   logic       step_pulse = 1'b0;
   logic       mem_req, mem_we, mem_ack;
   logic [3:0] mem_addr;
   logic [7:0] mem_wdata, mem_rdata;
   logic       out_valid, halted, cf, zf;
   logic [7:0] out_data;

   logic        run16 = 1'b0;
   logic        req16, ack16, halted16, cf16, zf16;
   logic        unused_we16, unused_ov16;
   logic [7:0]  addr16;
   logic [15:0] unused_wd16, unused_od16, rdata16;
   logic [15:0] mem16 [256];

   logic [7:0] mem [16];
   logic [7:0] img [16];
   logic       load = 1'b0;
   int dly = 0, wr_dly = 0, wcnt = 0, ocnt = 0, reqcnt = 0;
   int total = 0, bad = 0;

   int m_a, m_pc, m_cf, m_zf, m_halt, m_ocnt, m_out;
   int m_mem [16];
   int ops [11] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 14, 15};

   always #5 clk = ~clk;

   eater_cpu dut (
      .clk(clk), .clr(clr), .run_en(run_en),
      .step_pulse(step_pulse), .mem_req(mem_req),
      .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_ack(mem_ack), .out_valid(out_valid),
      .out_data(out_data), .halted(halted),
      .cf(cf), .zf(zf)
   );

   eater_cpu #(.DATA_W(16), .ADDR_W(8)) dut16 (
      .clk(clk), .clr(clr), .run_en(run16),
      .step_pulse(1'b0), .mem_req(req16),
      .mem_we(unused_we16), .mem_addr(addr16),
      .mem_wdata(unused_wd16), .mem_rdata(rdata16),
      .mem_ack(ack16), .out_valid(unused_ov16),
      .out_data(unused_od16), .halted(halted16),
      .cf(cf16), .zf(zf16)
   );

   assign ack16   = req16;
   assign rdata16 = mem16[addr16];

   // Memory responder: ack after a programmable number of wait cycles.
   assign mem_ack = mem_req
                 && (wcnt >= (mem_we ? wr_dly : dly));
   assign mem_rdata = mem[mem_addr];

   always @(posedge clk) begin
      ocnt   <= ocnt + int'(out_valid);
      reqcnt <= reqcnt + int'(mem_req);
      if (mem_req && !mem_ack) wcnt <= wcnt + 1;
      else                     wcnt <= 0;
      if (load) mem <= img;
      else if (mem_req && mem_ack && mem_we)
         mem[mem_addr] <= mem_wdata;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset;
      clr = 1'b0;
      tick();
      tick();
      clr = 1'b1;
      tick();
   endtask

   task automatic clear_img;
      for (int i = 0; i < 16; i++) img[i] = 8'h00;
   endtask

   task automatic load_prog;
      load = 1'b1;
      tick();
      load = 1'b0;
      for (int i = 0; i < 16; i++) m_mem[i] = int'(img[i]);
      m_a = 0; m_pc = 0; m_cf = 0; m_zf = 0;
      m_halt = 0; m_out = 0; m_ocnt = ocnt;
   endtask

   task automatic do_step;
      step_pulse = 1'b1;
      tick();
      step_pulse = 1'b0;
      repeat (14) tick();
   endtask

   // One instruction of the architectural machine.
   task automatic m_step;
      int ir, opc, opd, v;
      if (m_halt != 0) return;
      ir   = m_mem[m_pc];
      opc  = ir / 16;
      opd  = ir % 16;
      m_pc = (m_pc + 1) % 16;
      v    = m_mem[opd];
      case (opc)
         1: m_a = v;
         2: begin
            m_cf = int'(m_a + v > 255);
            m_a  = (m_a + v) % 256;
            m_zf = int'(m_a == 0);
         end
         3: begin
            m_cf = int'(m_a >= v);
            m_a  = (m_a - v + 256) % 256;
            m_zf = int'(m_a == 0);
         end
         4: m_mem[opd] = m_a;
         5: m_a = opd;
         6: m_pc = opd;
         7: if (m_cf != 0) m_pc = opd;
         8: if (m_zf != 0) m_pc = opd;
         14: begin m_out = m_a; m_ocnt++; end
         15: m_halt = 1;
         default: ;
      endcase
   endtask

   initial begin
      int base;
      for (int i = 0; i < 256; i++) mem16[i] = 16'h0000;
      mem16[0]     = 16'h1010;
      mem16[1]     = 16'h2011;
      mem16[2]     = 16'hF000;
      mem16[8'h10] = 16'hFFFF;
      mem16[8'h11] = 16'h0001;

      // reset values
      do_reset();
      chk("rst_req", 32'(mem_req), 0);
      chk("rst_we", 32'(mem_we), 0);
      chk("rst_halt", 32'(halted), 0);
      chk("rst_ov", 32'(out_valid), 0);
      chk("rst_od", 32'(out_data), 0);
      chk("rst_cf", 32'(cf), 0);
      chk("rst_zf", 32'(zf), 0);
      chk("rst_pc", 32'(dut.pc), 0);
      chk("rst_a", 32'(dut.a), 0);

      // 28 + 14 free-running
      clear_img();
      img[0] = 8'h1E; img[1] = 8'h2F;
      img[2] = 8'hE0; img[3] = 8'hF0;
      img[14] = 8'd28; img[15] = 8'd14;
      load_prog();
      base = ocnt;
      run_en = 1'b1;
      for (int i = 0; i < 100 && !halted; i++) tick();
      repeat (3) tick();
      run_en = 1'b0;
      chk("p1_halt", 32'(halted), 1);
      chk("p1_npulse", 32'(ocnt - base), 1);
      chk("p1_out", 32'(out_data), 42);
      chk("p1_cf", 32'(cf), 0);
      chk("p1_zf", 32'(zf), 0);

      // 5 - 5, then JZ taken
      do_reset();
      clear_img();
      img[0] = 8'h55; img[1] = 8'h3F;
      img[2] = 8'h89; img[15] = 8'h05;
      load_prog();
      repeat (3) do_step();
      chk("p2_a", 32'(dut.a), 0);
      chk("p2_zf", 32'(zf), 1);
      chk("p2_cf", 32'(cf), 1);
      chk("p2_pc", 32'(dut.pc), 9);

      // 15 + 0xF5 carries, JC taken
      do_reset();
      clear_img();
      img[0] = 8'h5F; img[1] = 8'h2E;
      img[2] = 8'h7C; img[14] = 8'hF5;
      load_prog();
      repeat (3) do_step();
      chk("p3_a", 32'(dut.a), 4);
      chk("p3_cf", 32'(cf), 1);
      chk("p3_zf", 32'(zf), 0);
      chk("p3_pc", 32'(dut.pc), 12);

      // 16-bit variant: 0xFFFF + 1
      run16 = 1'b1;
      for (int i = 0; i < 100 && !halted16; i++) tick();
      run16 = 1'b0;
      chk("w16_halt", 32'(halted16), 1);
      chk("w16_a", 32'(dut16.a), 0);
      chk("w16_cf", 32'(cf16), 1);
      chk("w16_zf", 32'(zf16), 1);

      // HLT latency of three cycles
      do_reset();
      clear_img();
      img[0] = 8'hF0;
      load_prog();
      step_pulse = 1'b1;
      tick();
      step_pulse = 1'b0;
      tick();
      chk("lat_hlt_early", 32'(halted), 0);
      tick();
      chk("lat_hlt", 32'(halted), 1);
      step_pulse = 1'b1;
      tick();
      step_pulse = 1'b0;
      chk("halt_stays", 32'(halted), 1);

      // ADD bus occupancy, zero-wait and one wait per access
      do_reset();
      clear_img();
      img[0] = 8'h2F; img[1] = 8'h2F; img[15] = 8'h03;
      load_prog();
      base = reqcnt;
      do_step();
      chk("add_req0", 32'(reqcnt - base), 2);
      chk("add_a0", 32'(dut.a), 3);
      dly = 1;
      base = reqcnt;
      do_step();
      chk("add_req1", 32'(reqcnt - base), 4);
      chk("add_a1", 32'(dut.a), 6);

      // fetch stretched by three wait cycles
      do_reset();
      clear_img();
      load_prog();
      dly = 3;
      step_pulse = 1'b1;
      tick();
      step_pulse = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("wait_req", 32'(mem_req), 1);
         chk("wait_addr", 32'(mem_addr), 0);
         chk("wait_pc", 32'(dut.pc), 0);
         tick();
      end
      chk("wait_done", 32'(mem_req), 0);
      chk("wait_pc_inc", 32'(dut.pc), 1);
      repeat (4) tick();
      chk("wait_pc_once", 32'(dut.pc), 1);
      dly = 0;

      // single step and PC wrap
      do_reset();
      clear_img();
      img[0] = 8'h6F;
      load_prog();
      do_step();
      chk("wrap_pc15", 32'(dut.pc), 15);
      do_step();
      chk("wrap_pc0", 32'(dut.pc), 0);
      chk("wrap_halt", 32'(halted), 0);

      // reset during a stalled store
      do_reset();
      clear_img();
      img[0] = 8'h59; img[1] = 8'h47; img[7] = 8'hAA;
      load_prog();
      do_step();
      wr_dly = 100;
      step_pulse = 1'b1;
      tick();
      step_pulse = 1'b0;
      tick();
      tick();
      chk("sta_req", 32'(mem_req), 1);
      chk("sta_we", 32'(mem_we), 1);
      chk("sta_addr", 32'(mem_addr), 7);
      chk("sta_wdata", 32'(mem_wdata), 9);
      tick();
      clr = 1'b0;
      #1;
      chk("clr_req", 32'(mem_req), 0);
      chk("clr_we", 32'(mem_we), 0);
      chk("clr_ov", 32'(out_valid), 0);
      chk("clr_od", 32'(out_data), 0);
      chk("clr_halt", 32'(halted), 0);
      chk("clr_a", 32'(dut.a), 0);
      tick();
      chk("clr_mem", 32'(mem[7]), 8'hAA);
      clr = 1'b1;
      tick();
      wr_dly = 0;

      // random programs against the reference model
      for (int t = 0; t < 4; t++) begin
         do_reset();
         for (int i = 0; i < 16; i++)
            img[i] = 8'((ops[$urandom_range(0, 10)] << 4)
                        | $urandom_range(0, 15));
         load_prog();
         for (int s = 0; s < 12; s++) begin
            dly = $urandom_range(0, 2);
            do_step();
            m_step();
            chk("rnd_a", 32'(dut.a), m_a);
            chk("rnd_pc", 32'(dut.pc), m_pc);
            chk("rnd_cf", 32'(cf), m_cf);
            chk("rnd_zf", 32'(zf), m_zf);
            chk("rnd_halt", 32'(halted), m_halt);
            chk("rnd_nout", 32'(ocnt), m_ocnt);
            if (m_ocnt > 0)
               chk("rnd_out", 32'(out_data), m_out);
         end
         for (int i = 0; i < 16; i++)
            chk("rnd_mem", 32'(mem[i]), m_mem[i]);
      end
      dly = 0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/eater_cpu.md
EATER_CPU -- requirements
Module: eater_cpu

Interface
REQ-001 Parameter DATA_W, default 8: accumulator, B register, memory word and instruction width.
REQ-002 Parameter ADDR_W, default 4: PC and memory address width; DATA_W >= 4+ADDR_W is enforced by an elaboration-time check.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 clr  in  1  reset, asynchronous, active-low.
REQ-005 run_en  in  1  free-run enable; sampled in IDLE.
REQ-006 step_pulse  in  1  single-cycle synchronous pulse; executes one instruction when run_en=0.
REQ-007 mem_req  out  1  memory access request, held until ack.
REQ-008 mem_we  out  1  1=write, 0=read; valid while mem_req=1.
REQ-009 mem_addr  out  ADDR_W  access address; stable while mem_req=1.
REQ-010 mem_wdata  out  DATA_W  write data (=A); stable while mem_req=1.
REQ-011 mem_rdata  in  DATA_W  read data; valid in the cycle mem_ack=1.
REQ-012 mem_ack  in  1  completes access at the edge where mem_req=1 and mem_ack=1; may be combinational (zero-wait).
REQ-013 out_valid  out  1  one-cycle strobe qualifying out_data.
REQ-014 out_data  out  DATA_W  output register, holds last OUT value.
REQ-015 halted  out  1  high in HALT state.
REQ-016 cf, zf  out  1 each  carry and zero flags.

Function
REQ-017 Instruction = opcode[DATA_W-1:DATA_W-4], operand[ADDR_W-1:0]; unused middle bits ignored.
REQ-018 Opcodes: 0 NOP, 1 LDA, 2 ADD, 3 SUB, 4 STA, 5 LDI, 6 JMP, 7 JC, 8 JZ, 14 OUT, 15 HLT; 9-13 behave as NOP.
REQ-019 States: IDLE, FETCH, DECODE, MEM_RD, ALU, MEM_WR, HALT; mem_req/mem_we/mem_addr decoded from state and registers only.
REQ-020 IDLE: -> FETCH if run_en=1 or step_pulse=1, else stay.
REQ-021 FETCH: read at PC; on ack IR<=mem_rdata, PC<=PC+1 mod 2^ADDR_W, -> DECODE.
REQ-022 DECODE: LDI A<=zero-extended operand; JMP PC<=operand; JC/JZ load PC only if cf/zf=1; OUT out_data<=A, out_valid=1 next cycle only; NOP/unused nothing; all these -> IDLE.
REQ-023 DECODE: LDA/ADD/SUB -> MEM_RD; STA -> MEM_WR; HLT -> HALT.
REQ-024 MEM_RD: read at operand; on ack LDA A<=rdata -> IDLE; ADD/SUB B<=rdata -> ALU.
REQ-025 ALU (1 cycle): ADD A<=A+B, cf=carry-out; SUB A<=A+~B+1, cf=carry-out (1 = no borrow); zf=(new A==0); -> IDLE; flags change only here.
REQ-026 MEM_WR: write A at operand, mem_we=1; on ack -> IDLE.
REQ-027 HALT: terminal; ignores run_en/step_pulse; exit only by reset.
REQ-028 Zero-wait latency: NOP/LDI/JMP/JC/JZ/OUT/HLT 3 cycles, LDA/STA 4, ADD/SUB 5; each ack wait cycle adds one.
REQ-029 mem_ack with mem_req=0 is ignored; step_pulse outside IDLE is ignored.

Reset
REQ-030 clr=0 immediately forces state IDLE, A=B=IR=PC=0, cf=zf=0, out_data=0, out_valid=0, halted=0, mem_req=0, mem_we=0.
REQ-031 Reset mid-access drops mem_req in the same cycle; no transfer completes.

Structure
REQ-032 Package eater_pkg holds opcode constants, state enum, default DATA_W/ADDR_W.
REQ-033 One sub-module alu_n (DATA_W parametrised add/sub, carry, zero), combinational; flag registers stay in eater_cpu.

Verification
REQ-034 mem[0..3]=LDA 14, ADD 15, OUT, HLT; mem[14]=28, mem[15]=14; run_en=1 -> one out_valid pulse, out_data=42, cf=0, zf=0, halted=1.
REQ-035 LDI 5; SUB 15 (mem[15]=5); JZ 9 -> A=0, zf=1, cf=1, PC=9 after JZ.
REQ-036 LDI 15; ADD 14 (mem[14]=0xF5); JC 12 -> A=0x04, cf=1, PC=12; DATA_W=16, ADDR_W=8 variant, 0xFFFF+1 -> A=0, cf=1, zf=1.
REQ-037 FETCH ack delayed 3 cycles -> mem_req, mem_addr stable 4 cycles, PC increments exactly once.
REQ-038 run_en=0, PC=15, one step_pulse -> exactly one instruction, return to IDLE, PC=0 (wrap).
REQ-039 clr low during MEM_WR wait -> mem_req=0 same cycle, memory unchanged, all outputs at reset values.
